// File: rtl/sprite_pkg.sv
// Shared types for the sprite ROM address stepper.
// Holds the per-button key FSM state encoding.
package sprite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEB_DN,
        FIRE,
        HOLD_DLY,
        RPT,
        HOLD_RATE,
        DEB_UP
    } key_state_t;

    localparam int unsigned KEY_CNT_W = 32;

endpackage

// File: rtl/key_repeat_fsm.sv
// Per-button synchroniser, debounce and hold-to-repeat pulse generator.
// Ports: Clk, Reset (sync, active high), key_n (async, active low),
//        pulse (1-cycle step request on press and on each auto-repeat).
module key_repeat_fsm
    import sprite_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic key_n,
    output logic pulse
);

    localparam logic [KEY_CNT_W-1:0] DEB_LAST = KEY_CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [KEY_CNT_W-1:0] DLY_LAST = KEY_CNT_W'(REPEAT_DELAY - 1);
    localparam logic [KEY_CNT_W-1:0] RPT_LAST = KEY_CNT_W'(REPEAT_RATE - 1);

    logic                 sync_q1;
    logic                 pr;
    key_state_t           state_q;
    key_state_t           state_d;
    logic [KEY_CNT_W-1:0] cnt_q;
    logic [KEY_CNT_W-1:0] cnt_d;

    // sync_q1/pr form the 2-FF synchroniser; pr is active-high press.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q1 <= 1'b0;
            pr      <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync_q1 <= ~key_n;
            pr      <= sync_q1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pr) begin
                    state_d = DEB_DN;
                    cnt_d   = '0;
                end
            end
            DEB_DN: begin
                if (!pr)                  state_d = IDLE;
                else if (cnt_q == DEB_LAST) state_d = FIRE;
                else                      cnt_d   = cnt_q + 1'b1;
            end
            FIRE: begin
                pulse   = 1'b1;
                state_d = HOLD_DLY;
                cnt_d   = '0;
            end
            HOLD_DLY: begin
                if (!pr) begin
                    state_d = DEB_UP;
                    cnt_d   = '0;
                end else if (cnt_q == DLY_LAST) begin
                    state_d = RPT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RPT: begin
                pulse   = 1'b1;
                state_d = HOLD_RATE;
                cnt_d   = '0;
            end
            HOLD_RATE: begin
                if (!pr) begin
                    state_d = DEB_UP;
                    cnt_d   = '0;
                end else if (cnt_q == RPT_LAST) begin
                    state_d = RPT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEB_UP: begin
                // A bounce back to pressed restarts the release timer.
                if (pr)                   cnt_d   = '0;
                else if (cnt_q == DEB_LAST) state_d = IDLE;
                else                      cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/sprite_addr_stepper.sv
// Sprite ROM address stepper driven by inc/dec push buttons.
// Ports: Clk, Reset (sync, active high), key_inc_n/key_dec_n (active low),
//        enable, load_en, load_addr -> address, step_valid, wrapped.
module sprite_addr_stepper
    import sprite_pkg::*;
#(
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned ADDR_MAX     = 2047,
    parameter int unsigned STEP         = 1,
    parameter int unsigned WRAP         = 1,
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              key_inc_n,
    input  logic              key_dec_n,
    input  logic              enable,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] address,
    output logic              step_valid,
    output logic              wrapped
);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   addr_x_t;

    // One extra bit so address+STEP and address+ADDR_MAX+1 never overflow.
    localparam addr_x_t MAX_X  = addr_x_t'(ADDR_MAX);
    localparam addr_x_t STEP_X = addr_x_t'(STEP);
    localparam addr_x_t SPAN_X = addr_x_t'(ADDR_MAX + 1);

    logic    inc_pulse;
    logic    dec_pulse;
    addr_x_t addr_x;
    addr_x_t inc_x;
    logic    inc_over;
    logic    dec_under;
    logic    load_over;
    logic    do_step;
    logic    do_load;
    logic    do_inc;
    logic    do_dec;
    addr_t   addr_d;
    logic    valid_d;
    logic    wrap_d;

    key_repeat_fsm #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_key_inc (
        .Clk   (Clk),
        .Reset (Reset),
        .key_n (key_inc_n),
        .pulse (inc_pulse)
    );

    key_repeat_fsm #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_key_dec (
        .Clk   (Clk),
        .Reset (Reset),
        .key_n (key_dec_n),
        .pulse (dec_pulse)
    );

    assign addr_x    = {1'b0, address};
    assign inc_x     = addr_x + STEP_X;
    assign inc_over  = inc_x > MAX_X;
    assign dec_under = addr_x < STEP_X;
    assign load_over = {1'b0, load_addr} > MAX_X;

    // Both buttons on the same cycle cancel out.
    assign do_step = enable & (inc_pulse ^ dec_pulse);
    assign do_load = load_en;
    assign do_inc  = ~load_en & do_step & inc_pulse;
    assign do_dec  = ~load_en & do_step & dec_pulse;

    always_comb begin
        addr_d  = address;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        unique case (1'b1)
            do_load: begin
                addr_d = load_over ? addr_t'(MAX_X) : load_addr;
            end
            do_inc: begin
                valid_d = 1'b1;
                wrap_d  = inc_over;
                if (!inc_over)      addr_d = addr_t'(inc_x);
                else if (WRAP != 0) addr_d = addr_t'(inc_x - SPAN_X);
                else                addr_d = addr_t'(MAX_X);
            end
            do_dec: begin
                valid_d = 1'b1;
                wrap_d  = dec_under;
                if (!dec_under)     addr_d = addr_t'(addr_x - STEP_X);
                else if (WRAP != 0) addr_d = addr_t'(addr_x + SPAN_X - STEP_X);
                else                addr_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            address    <= '0;
            step_valid <= 1'b0;
            wrapped    <= 1'b0;
        end else begin
            address    <= addr_d;
            step_valid <= valid_d;
            wrapped    <= wrap_d;
        end
    end

endmodule

// File: tb/tb_sprite_addr_stepper.sv
// Bench for sprite_addr_stepper: directed and random button/load/reset
// stimulus compared every cycle against a press-timing model.
module tb_sprite_addr_stepper;

    localparam int AW   = 4;
    localparam int AMAX = 9;
    localparam int STP  = 1;
    localparam int DEB  = 4;
    localparam int DLY  = 20;
    localparam int RATE = 5;
    localparam int N    = 512;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          key_inc_n = 1'b1;
    logic          key_dec_n = 1'b1;
    logic          enable = 1'b1;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [AW-1:0] address_w;
    logic          step_valid_w;
    logic          wrapped_w;
    logic [AW-1:0] address_s;
    logic          step_valid_s;
    logic          wrapped_s;

    int n_tests = 0;
    int n_fail  = 0;

    bit inc_low [N];
    bit dec_low [N];
    bit rst_v   [N];
    bit en_v    [N];
    bit ld_v    [N];
    int ld_a    [N];
    bit inc_p   [N];
    bit dec_p   [N];
    int hist_w  [N];
    int seg_len;
    int sv_cnt_w, wr_cnt_w, sv_cnt_s, wr_cnt_s;

    always #5 Clk = ~Clk;

    sprite_addr_stepper #(
        .ADDR_W(AW), .ADDR_MAX(AMAX), .STEP(STP), .WRAP(1),
        .DEBOUNCE_CYC(DEB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
    ) u_dut_wrap (
        .Clk(Clk), .Reset(Reset),
        .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
        .enable(enable), .load_en(load_en), .load_addr(load_addr),
        .address(address_w), .step_valid(step_valid_w), .wrapped(wrapped_w)
    );

    sprite_addr_stepper #(
        .ADDR_W(AW), .ADDR_MAX(AMAX), .STEP(STP), .WRAP(0),
        .DEBOUNCE_CYC(DEB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
    ) u_dut_sat (
        .Clk(Clk), .Reset(Reset),
        .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
        .enable(enable), .load_en(load_en), .load_addr(load_addr),
        .address(address_s), .step_valid(step_valid_s), .wrapped(wrapped_s)
    );

    task automatic check(input string tag, input int unsigned got,
                         input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void clear_seg(input int len);
        seg_len = len;
        for (int t = 0; t < N; t++) begin
            inc_low[t] = 0; dec_low[t] = 0; rst_v[t] = 0;
            en_v[t] = 1; ld_v[t] = 0; ld_a[t] = 0;
        end
        rst_v[0] = 1;
        rst_v[1] = 1;
    endfunction

    function automatic void add_press(input bit dec, input int n, input int len);
        for (int k = 0; k < len; k++)
            if (n + k < seg_len) begin
                if (dec) dec_low[n + k] = 1;
                else     inc_low[n + k] = 1;
            end
    endfunction

    function automatic bit low(input bit dec, input int t);
        return dec ? dec_low[t] : inc_low[t];
    endfunction

    // Edge u carries a pulse when the press (pin sampled low from edge n,
    // unbroken by reset) has lasted long enough for debounce or a repeat.
    // FIRE is entered at n+2+DEB, repeats DLY+1 then RATE+1 later; each
    // needs pr still seen, and the address moves one edge after entry.
    function automatic void sched(input bit dec);
        int n, len, lim, e, k;
        bit by_rst;
        for (int t = 0; t < N; t++) begin
            if (dec) dec_p[t] = 0;
            else     inc_p[t] = 0;
        end
        n = 0;
        while (n < seg_len) begin
            if (low(dec, n) && !rst_v[n]) begin
                len = 0;
                while (n + len < seg_len && low(dec, n + len) && !rst_v[n + len])
                    len++;
                by_rst = (n + len < seg_len) && rst_v[n + len];
                lim = by_rst ? len - 1 : len + 1;
                e = 2 + DEB;
                k = 0;
                while (e <= lim) begin
                    if (n + e + 1 < seg_len) begin
                        if (dec) dec_p[n + e + 1] = 1;
                        else     inc_p[n + e + 1] = 1;
                    end
                    e += (k == 0) ? DLY + 1 : RATE + 1;
                    k++;
                end
                n += len;
            end else begin
                n++;
            end
        end
    endfunction

    function automatic void mstep(input bit wrap, input int t, inout int a,
                                  output bit sv, output bit wr);
        sv = 0;
        wr = 0;
        if (rst_v[t]) begin
            a = 0;
        end else if (ld_v[t]) begin
            a = (ld_a[t] > AMAX) ? AMAX : ld_a[t];
        end else if (en_v[t] && (inc_p[t] != dec_p[t])) begin
            sv = 1;
            if (inc_p[t]) begin
                wr = (a + STP > AMAX);
                if (!wr)      a = a + STP;
                else if (wrap) a = (a + STP) % (AMAX + 1);
                else          a = AMAX;
            end else begin
                wr = (a < STP);
                if (!wr)      a = a - STP;
                else if (wrap) a = (a - STP + AMAX + 1) % (AMAX + 1);
                else          a = 0;
            end
        end
    endfunction

    task automatic run_seg(input string name);
        int ma_w, ma_s;
        bit sv_w, wr_w, sv_s, wr_s;
        ma_w = 0;
        ma_s = 0;
        sv_cnt_w = 0; wr_cnt_w = 0; sv_cnt_s = 0; wr_cnt_s = 0;
        sched(0);
        sched(1);
        for (int t = 0; t < seg_len; t++) begin
            key_inc_n = !inc_low[t];
            key_dec_n = !dec_low[t];
            Reset     = rst_v[t];
            enable    = en_v[t];
            load_en   = ld_v[t];
            load_addr = AW'(ld_a[t]);
            @(posedge Clk);
            #1;
            mstep(1, t, ma_w, sv_w, wr_w);
            mstep(0, t, ma_s, sv_s, wr_s);
            check($sformatf("%s addr_w t=%0d", name, t), address_w, ma_w);
            check($sformatf("%s valid_w t=%0d", name, t), step_valid_w, sv_w);
            check($sformatf("%s wrap_w t=%0d", name, t), wrapped_w, wr_w);
            check($sformatf("%s addr_s t=%0d", name, t), address_s, ma_s);
            check($sformatf("%s valid_s t=%0d", name, t), step_valid_s, sv_s);
            check($sformatf("%s wrap_s t=%0d", name, t), wrapped_s, wr_s);
            hist_w[t] = int'(address_w);
            sv_cnt_w += int'(step_valid_w);
            wr_cnt_w += int'(wrapped_w);
            sv_cnt_s += int'(step_valid_s);
            wr_cnt_s += int'(wrapped_s);
        end
    endtask

    initial begin
        int pos, len;

        clear_seg(40);
        add_press(0, 5, 3);
        run_seg("tap");
        check("reset_addr", hist_w[1], 0);
        check("tap_addr", address_w, 0);
        check("tap_steps", sv_cnt_w, 0);

        clear_seg(40);
        add_press(0, 5, 10);
        run_seg("clean");
        check("clean_before", hist_w[11], 0);
        check("clean_at_n7", hist_w[12], 1);
        check("clean_steps", sv_cnt_w, 1);

        clear_seg(60);
        add_press(0, 5, 40);
        run_seg("repeat");
        check("rpt_second", hist_w[33], 2);
        check("rpt_addr", address_w, 4);
        check("rpt_steps", sv_cnt_w, 4);

        clear_seg(30);
        ld_v[3] = 1; ld_a[3] = 9;
        add_press(0, 5, 6);
        run_seg("wrap");
        check("wrap_addr", address_w, 0);
        check("wrap_flag", wr_cnt_w, 1);
        check("sat_hi_addr", address_s, 9);
        check("sat_hi_flag", wr_cnt_s, 1);

        clear_seg(30);
        ld_v[3] = 1; ld_a[3] = 0;
        add_press(1, 5, 6);
        run_seg("dec0");
        check("sat_lo_addr", address_s, 0);
        check("sat_lo_flag", wr_cnt_s, 1);
        check("dec_wrap_addr", address_w, 9);

        clear_seg(30);
        add_press(0, 5, 6);
        add_press(1, 5, 6);
        run_seg("both");
        check("both_addr", address_w, 0);
        check("both_steps", sv_cnt_w, 0);

        clear_seg(30);
        add_press(0, 5, 6);
        ld_v[12] = 1; ld_a[12] = 12;
        run_seg("ldprio");
        check("ld_clamp", hist_w[12], 9);
        check("ld_steps", sv_cnt_w, 0);

        clear_seg(44);
        add_press(0, 5, 39);
        rst_v[35] = 1;
        run_seg("rsthold");
        check("rst_pre", hist_w[34], 2);
        check("rst_clear", hist_w[35], 0);
        check("rst_wait", hist_w[42], 0);
        check("rst_step", hist_w[43], 1);

        for (int s = 0; s < 10; s++) begin
            clear_seg(400);
            for (int b = 0; b < 2; b++) begin
                pos = 3 + int'($urandom_range(0, 20));
                while (pos < seg_len) begin
                    len = int'($urandom_range(1, 50));
                    add_press(b[0], pos, len);
                    pos += len + 12 + int'($urandom_range(0, 30));
                end
            end
            for (int t = 2; t < seg_len; t++) begin
                en_v[t]  = ($urandom_range(0, 9) != 0);
                ld_v[t]  = ($urandom_range(0, 49) == 0);
                ld_a[t]  = int'($urandom_range(0, 15));
                rst_v[t] = ($urandom_range(0, 299) == 0);
            end
            run_seg($sformatf("rand%0d", s));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
